pipeline_control: RTL and testbench

Parametrised pipeline control for the 5-stage RV32I core. Decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards, branch/jump flushes and data-memory wait states, and generates stall, flush and bubble signals for the datapath. Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/pipe_ctrl_decode.sv | 74 +++++++
 rtl/pipeline_control.sv | 146 ++++++++++++++
 tb/tb_pipeline_control.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the RV32I pipeline control block.
//   - opcode constants for the instruction classes the decoder recognises
//   - 2-bit ALUOp encodings (zero-extended to ALUOP_W at the ports)
//   - ctrl_bundle_t: the control word carried through ID/EX, EX/MEM, MEM/WB
//   - BUBBLE: all-zero bundle used for stalls, flushes and reset
//   - uses_rs2(): whether an instruction class actually reads rs2
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_UPPER  = 2'b11;

  // The bundle stores rd at a fixed width so the struct can live in a
  // package; the top zero-extends/slices to REG_AW, which must not exceed it.
  localparam int RD_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [1:0]          alu_op;
    logic                alu_src;
    logic                branch;
    logic                jump;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                mem_to_reg;
    logic                illegal;
    logic [RD_MAX_W-1:0] rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: combinational main decoder.
// Ports:
//   opcode  in  7       instruction[6:0] from IF/ID
//   rd      in  REG_AW  destination register index
//   bundle  out         decoded ctrl_bundle_t; valid=1 for legal opcodes,
//                       illegal opcodes give an all-zero bundle with illegal=1
// The caller is responsible for gating the result with the IF/ID valid bit.
module pipe_ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [6:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  output ctrl_bundle_t      bundle
);

  always_comb begin
    bundle       = BUBBLE;
    bundle.valid = 1'b1;
    bundle.rd    = RD_MAX_W'(rd);
    unique case (opcode)
      OP_R: begin
        bundle.reg_write = 1'b1;
        bundle.alu_op    = ALUOP_FUNCT;
      end
      OP_IMM: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = ALUOP_FUNCT;
      end
      OP_LOAD: begin
        bundle.reg_write  = 1'b1;
        bundle.mem_read   = 1'b1;
        bundle.mem_to_reg = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        bundle.mem_write = 1'b1;
        bundle.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        bundle.branch = 1'b1;
        bundle.alu_op = ALUOP_BRANCH;
      end
      OP_JAL: begin
        bundle.jump      = 1'b1;
        bundle.reg_write = 1'b1;
      end
      OP_JALR: begin
        bundle.jump      = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = ALUOP_UPPER;
      end
      default: begin
        // Unknown opcode: behaves as a bubble downstream but keeps the flag
        // so the trap logic in EX can see it.
        bundle         = BUBBLE;
        bundle.illegal = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally discarded; drop them at the source.
    if (rd == '0) begin
      bundle.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: control path of the 5-stage RV32I core.
// Decodes the ID opcode, carries the control bundle through ID/EX (p0),
// EX/MEM (p1) and MEM/WB (p2), and resolves hazards with the priority
// freeze (data memory wait) > flush (taken branch/jump) > load-use stall.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid, id_opcode        IF/ID instruction presence and opcode
//   id_rs1, id_rs2, id_rd      register indices of the ID instruction
//   ex_branch_taken            redirect request from EX
//   mem_ready                  data memory completed the MEM access
//   stall_if_id, flush_if_id   combinational IF/ID hold and clear
//   ex_*                       ID/EX register contents
//   mem_*                      EX/MEM register contents
//   wb_*                       MEM/WB register contents
//   stall_cnt                  saturating count of cycles with stall_if_id
module pipeline_control
  import ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [6:0]         id_opcode,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_branch_taken,
  input  logic               mem_ready,
  output logic               stall_if_id,
  output logic               flush_if_id,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_mem_read,
  output logic               ex_illegal,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               mem_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_reg_write,
  output logic [REG_AW-1:0]  mem_rd,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [CNT_W-1:0]   stall_cnt
);

  ctrl_bundle_t dec;
  ctrl_bundle_t id_bundle;
  ctrl_bundle_t ctrl_p0;   // ID/EX
  ctrl_bundle_t ctrl_p1;   // EX/MEM
  ctrl_bundle_t ctrl_p2;   // MEM/WB

  logic              freeze;
  logic              flush;
  logic              load_use;
  logic              rs_hit;
  logic [REG_AW-1:0] p0_rd;
  logic              unused_bits;

  pipe_ctrl_decode #(
    .REG_AW (REG_AW)
  ) u_decode (
    .opcode (id_opcode),
    .rd     (id_rd),
    .bundle (dec)
  );

  always_comb begin
    id_bundle = dec;
    if (!id_valid) begin
      id_bundle = BUBBLE;
    end
  end

  assign p0_rd = ctrl_p0.rd[REG_AW-1:0];

  // A load in EX blocks a dependent consumer in ID; rs2 only counts for
  // the formats that really read it (I-type immediates alias that field).
  assign rs_hit = (p0_rd == id_rs1) ||
                  (uses_rs2(id_opcode) && (p0_rd == id_rs2));

  assign freeze   = ctrl_p1.valid && (ctrl_p1.mem_read || ctrl_p1.mem_write) && !mem_ready;
  assign flush    = !freeze && ctrl_p0.valid && ex_branch_taken;
  assign load_use = !freeze && !flush && ctrl_p0.valid && ctrl_p0.mem_read &&
                    (p0_rd != '0) && id_valid && rs_hit;

  assign stall_if_id = freeze || load_use;
  assign flush_if_id = flush;

  // ---- ID -> EX / EX -> MEM / MEM -> WB stage registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_p0 <= BUBBLE;
      ctrl_p1 <= BUBBLE;
      ctrl_p2 <= BUBBLE;
    end else if (freeze) begin
      // EX and MEM hold; WB drains so the stalled access is not retired twice.
      ctrl_p2 <= BUBBLE;
    end else begin
      ctrl_p0 <= (flush || load_use) ? BUBBLE : id_bundle;
      ctrl_p1 <= ctrl_p0;
      ctrl_p2 <= ctrl_p1;
    end
  end

  // ---- stall-cycle counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_if_id && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_valid    = ctrl_p0.valid;
  assign ex_alu_op   = ALUOP_W'(ctrl_p0.alu_op);
  assign ex_alu_src  = ctrl_p0.alu_src;
  assign ex_branch   = ctrl_p0.branch;
  assign ex_jump     = ctrl_p0.jump;
  assign ex_mem_read = ctrl_p0.mem_read;
  assign ex_illegal  = ctrl_p0.illegal;
  assign ex_rd       = p0_rd;

  assign mem_valid     = ctrl_p1.valid;
  assign mem_read      = ctrl_p1.mem_read;
  assign mem_write     = ctrl_p1.mem_write;
  assign mem_reg_write = ctrl_p1.reg_write;
  assign mem_rd        = ctrl_p1.rd[REG_AW-1:0];

  assign wb_valid      = ctrl_p2.valid;
  assign wb_reg_write  = ctrl_p2.reg_write;
  assign wb_mem_to_reg = ctrl_p2.mem_to_reg;
  assign wb_rd         = ctrl_p2.rd[REG_AW-1:0];

  // Bundle fields that a later stage no longer exports are folded here so
  // they are not reported as dead logic.
  assign unused_bits = ^{ctrl_p0, ctrl_p1, ctrl_p2};

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: each scenario pushes the expected
// WB bundle (with its expected arrival cycle) when it drives an instruction,
// and the cycle task pops and compares whenever wb_valid appears.
module tb_pipeline_control;

  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 2;
  localparam int CNT_W   = 16;

  localparam logic [6:0] R_T = 7'b0110011, IMM = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid;
  logic [6:0] id_opcode;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic ex_branch_taken, mem_ready;
  logic stall_if_id, flush_if_id;
  logic ex_valid, ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_illegal;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic mem_valid, mem_read, mem_write, mem_reg_write;
  logic wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [CNT_W-1:0] stall_cnt;

  // second instance with a 2-bit counter for saturation
  logic s_stall, s_flush, s_ex_valid, s_ex_alu_src, s_ex_branch, s_ex_jump, s_ex_mem_read, s_ex_illegal;
  logic [ALUOP_W-1:0] s_ex_alu_op;
  logic [REG_AW-1:0] s_ex_rd, s_mem_rd, s_wb_rd;
  logic s_mem_valid, s_mem_read, s_mem_write, s_mem_reg_write;
  logic s_wb_valid, s_wb_reg_write, s_wb_mem_to_reg;
  logic [1:0] s_stall_cnt;

  always #5 clk = ~clk;

  pipeline_control #(.REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_mem_read(ex_mem_read),
    .ex_illegal(ex_illegal), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .stall_cnt(stall_cnt)
  );

  pipeline_control #(.REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .stall_if_id(s_stall), .flush_if_id(s_flush),
    .ex_valid(s_ex_valid), .ex_alu_op(s_ex_alu_op), .ex_alu_src(s_ex_alu_src),
    .ex_branch(s_ex_branch), .ex_jump(s_ex_jump), .ex_mem_read(s_ex_mem_read),
    .ex_illegal(s_ex_illegal), .ex_rd(s_ex_rd),
    .mem_valid(s_mem_valid), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .mem_reg_write(s_mem_reg_write), .mem_rd(s_mem_rd),
    .wb_valid(s_wb_valid), .wb_reg_write(s_wb_reg_write), .wb_mem_to_reg(s_wb_mem_to_reg),
    .wb_rd(s_wb_rd), .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic       alu_src, branch, jump, mem_read, mem_write, reg_write, mem_to_reg, illegal;
  } exp_t;

  typedef struct {
    logic              rw;
    logic              m2r;
    logic [REG_AW-1:0] rd;
    int                cyc;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  // Reference decode written directly from the opcode table.
  function automatic exp_t model(input logic [6:0] op, input logic [REG_AW-1:0] rd);
    exp_t e = '0;
    e.valid = 1'b1;
    case (op)
      R_T:         begin e.reg_write = 1; e.alu_op = 2'b10; end
      IMM:         begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 2'b10; end
      LD:          begin e.reg_write = 1; e.mem_read = 1; e.mem_to_reg = 1; e.alu_src = 1; end
      ST:          begin e.mem_write = 1; e.alu_src = 1; end
      BR:          begin e.branch = 1; e.alu_op = 2'b01; end
      JAL:         begin e.jump = 1; e.reg_write = 1; end
      JALR:        begin e.jump = 1; e.reg_write = 1; e.alu_src = 1; end
      LUI, AUIPC:  begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 2'b11; end
      default:     begin e = '0; e.illegal = 1; end
    endcase
    if (rd == 0) e.reg_write = 1'b0;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [6:0] op, input logic [REG_AW-1:0] rs1,
                       input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd);
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
  endtask

  task automatic push_exp(input logic [6:0] op, input logic [REG_AW-1:0] rd, input int lat);
    sb_t  s;
    exp_t e = model(op, rd);
    s.rw = e.reg_write; s.m2r = e.mem_to_reg; s.rd = rd; s.cyc = cyc + lat;
    sb.push_back(s);
  endtask

  // One clock: sample just after the edge and retire any WB bundle.
  task automatic step();
    sb_t s;
    @(posedge clk); #1;
    cyc++;
    if (wb_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: cyc=%0d rd=%0d want=no retirement", cyc, wb_rd);
      end else begin
        s = sb.pop_front();
        if ({wb_reg_write, wb_mem_to_reg, wb_rd} !== {s.rw, s.m2r, s.rd} || cyc != s.cyc) begin
          bad++;
          $display("FAIL wb_bundle: got rw=%0b m2r=%0b rd=%0d cyc=%0d want rw=%0b m2r=%0b rd=%0d cyc=%0d",
                   wb_reg_write, wb_mem_to_reg, wb_rd, cyc, s.rw, s.m2r, s.rd, s.cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_branch_taken = 1'b0; mem_ready = 1'b1;
    drive(1'b0, 7'd0, 0, 0, 0);
    #1;
    total++;
    if ({stall_if_id, flush_if_id, ex_valid, ex_alu_op, ex_illegal, ex_rd, mem_valid, mem_rd,
         wb_valid, wb_rd, stall_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero ex_valid=%0b stall_cnt=%0d want all 0", ex_valid, stall_cnt);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ex_valid !== 1'b0 || stall_cnt !== '0) begin
      bad++; $display("FAIL reset_release: ex_valid=%0b stall_cnt=%0d want 0 0", ex_valid, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    drive(1, LD, 1, 0, 5); push_exp(LD, 5, 3); #1;
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL lu_pre_stall: got=%0b want=0", stall_if_id); end
    step();
    total++;
    if ({ex_valid, ex_mem_read, ex_alu_src, ex_alu_op, ex_rd} !== {1'b1, 1'b1, 1'b1, 2'b00, 5'd5}) begin
      bad++; $display("FAIL lu_load_in_ex: got v=%0b mr=%0b rd=%0d want 1 1 5", ex_valid, ex_mem_read, ex_rd);
    end
    drive(1, R_T, 5, 1, 6); push_exp(R_T, 6, 4); #1;
    total++;
    if ({stall_if_id, flush_if_id} !== 2'b10) begin
      bad++; $display("FAIL lu_stall: got stall=%0b flush=%0b want 1 0", stall_if_id, flush_if_id);
    end
    step();
    total++;
    if (ex_valid !== 1'b0 || {mem_valid, mem_read, mem_rd} !== {1'b1, 1'b1, 5'd5}) begin
      bad++; $display("FAIL lu_bubble: got ex_valid=%0b mem_rd=%0d want 0 5", ex_valid, mem_rd);
    end
    #1;
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL lu_release: got=%0b want=0", stall_if_id); end
    step();
    total++;
    if ({ex_valid, ex_rd, ex_alu_op} !== {1'b1, 5'd6, 2'b10}) begin
      bad++; $display("FAIL lu_add_in_ex: got v=%0b rd=%0d op=%0d want 1 6 2", ex_valid, ex_rd, ex_alu_op);
    end
    drive(0, 7'd0, 0, 0, 0);
    step(); step();
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt: got=%0d want=1", stall_cnt); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL lu_drain: left=%0d want=0", sb.size()); end
  endtask

  task automatic test_no_false_stall();
    int c0 = int'(stall_cnt);
    drive(1, LD, 1, 0, 5); push_exp(LD, 5, 3); step();
    drive(1, IMM, 2, 5, 11); push_exp(IMM, 11, 3); #1;
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL nfs_rs2_imm: got=%0b want=0", stall_if_id); end
    step();
    drive(1, LD, 3, 0, 0); push_exp(LD, 0, 3); step();
    drive(1, R_T, 0, 0, 12); push_exp(R_T, 12, 3); #1;
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL nfs_x0_load: got=%0b want=0", stall_if_id); end
    step();
    drive(0, 7'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    total++; if (int'(stall_cnt) != c0) begin bad++; $display("FAIL nfs_cnt: got=%0d want=%0d", stall_cnt, c0); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL nfs_drain: left=%0d want=0", sb.size()); end
  endtask

  task automatic test_flush();
    int c0;
    drive(1, LD, 2, 0, 7); push_exp(LD, 7, 3); step();
    drive(1, BR, 3, 4, 0); push_exp(BR, 0, 3); #1;
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL fl_pre: got=%0b want=0", stall_if_id); end
    step();
    drive(1, R_T, 7, 7, 8); ex_branch_taken = 1'b1; #1;
    total++;
    if ({flush_if_id, stall_if_id} !== 2'b10) begin
      bad++; $display("FAIL fl_signals: got flush=%0b stall=%0b want 1 0", flush_if_id, stall_if_id);
    end
    c0 = int'(stall_cnt);
    step();
    ex_branch_taken = 1'b0; drive(0, 7'd0, 0, 0, 0);
    total++;
    if (ex_valid !== 1'b0 || {mem_valid, mem_reg_write} !== 2'b10) begin
      bad++; $display("FAIL fl_bubble: got ex_valid=%0b mem_valid=%0b want 0 1", ex_valid, mem_valid);
    end
    total++; if (int'(stall_cnt) != c0) begin bad++; $display("FAIL fl_cnt: got=%0d want=%0d", stall_cnt, c0); end
    step(); step(); step();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL fl_drain: left=%0d want=0", sb.size()); end
  endtask

  task automatic test_freeze();
    int c0 = int'(stall_cnt);
    drive(1, ST, 1, 2, 3); push_exp(ST, 3, 6); step();
    drive(1, IMM, 4, 0, 9); push_exp(IMM, 9, 6); mem_ready = 1'b0; #1;
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL fz_ready_idle: got=%0b want=0", stall_if_id); end
    step();
    drive(0, 7'd0, 0, 0, 0); ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({stall_if_id, flush_if_id} !== 2'b10) begin
        bad++; $display("FAIL fz_signals[%0d]: got stall=%0b flush=%0b want 1 0", i, stall_if_id, flush_if_id);
      end
      step();
      total++;
      if ({mem_valid, mem_write, mem_rd, ex_valid, ex_rd, wb_valid} !== {1'b1, 1'b1, 5'd3, 1'b1, 5'd9, 1'b0}) begin
        bad++; $display("FAIL fz_hold[%0d]: got mem_rd=%0d ex_rd=%0d wb_valid=%0b want 3 9 0", i, mem_rd, ex_rd, wb_valid);
      end
    end
    ex_branch_taken = 1'b0; mem_ready = 1'b1; #1;
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL fz_resume: got=%0b want=0", stall_if_id); end
    step(); step();
    total++; if (int'(stall_cnt) != c0 + 3) begin bad++; $display("FAIL fz_cnt: got=%0d want=%0d", stall_cnt, c0 + 3); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL fz_drain: left=%0d want=0", sb.size()); end
  endtask

  task automatic test_decode_back_to_back();
    logic [6:0] ops [11] = '{R_T, IMM, LD, ST, BR, JAL, JALR, LUI, AUIPC, 7'b1111111, 7'b0000000};
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      drive(1, ops[i], 0, 0, 5'(i + 1));
      e = model(ops[i], 5'(i + 1));
      if (e.valid) push_exp(ops[i], 5'(i + 1), 3);
      step();
      total++;
      if ({ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_illegal} !==
          {e.valid, e.alu_op, e.alu_src, e.branch, e.jump, e.mem_read, e.illegal} ||
          ex_rd !== (e.valid ? 5'(i + 1) : 5'd0)) begin
        bad++; $display("FAIL dec_op%b: got v=%0b op=%0d src=%0b br=%0b j=%0b mr=%0b ill=%0b rd=%0d want v=%0b op=%0d ill=%0b",
                        ops[i], ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_illegal, ex_rd,
                        e.valid, e.alu_op, e.illegal);
      end
    end
    drive(1, IMM, 1, 0, 0); push_exp(IMM, 0, 3); step();
    drive(0, 7'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL dec_drain: left=%0d want=0", sb.size()); end
  endtask

  task automatic test_reset_mid_freeze();
    drive(1, LD, 1, 0, 4); step();
    drive(0, 7'd0, 0, 0, 0); step();
    mem_ready = 1'b0; step();
    #2 rst_n = 1'b0; #1;
    total++;
    if ({stall_if_id, flush_if_id, ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_mem_read,
         ex_illegal, ex_rd, mem_valid, mem_read, mem_write, mem_reg_write, mem_rd, wb_valid,
         wb_reg_write, wb_mem_to_reg, wb_rd, stall_cnt, s_stall_cnt} !== '0) begin
      bad++; $display("FAIL rst_async: got stall=%0b mem_valid=%0b cnt=%0d want all 0", stall_if_id, mem_valid, stall_cnt);
    end
    sb.delete();
    mem_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    step();
    total++; if ({ex_valid, mem_valid, stall_if_id} !== 3'b000) begin bad++; $display("FAIL rst_after: got nonzero want 0"); end
  endtask

  task automatic test_saturate();
    drive(1, LD, 1, 0, 4); push_exp(LD, 4, 8); step();
    drive(0, 7'd0, 0, 0, 0); step();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++; if (s_stall_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt2: got=%0d want=3", s_stall_cnt); end
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL sat_cnt16: got=%0d want=5", stall_cnt); end
    mem_ready = 1'b1; step();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sat_drain: left=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_freeze();
    test_decode_back_to_back();
    test_reset_mid_freeze();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
